// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NUM_REQ requesters.
// One access issued per cycle; read data routed back to its requester via a 2-stage tag pipe.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic [WIDTH-1:0]              mem_rdata,
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  tag0_vld_q, tag0_vld_d;
  logic [IDX_W-1:0]      tag0_idx_q, tag0_idx_d;
  logic                  tag1_vld_q, tag1_vld_d;
  logic [IDX_W-1:0]      tag1_idx_q, tag1_idx_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]    grant;
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;

  // Rotating-priority search from rr_ptr, then mux out the winner's request fields.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
      end
    end
    if (rst) begin
      grant     = '0;
      grant_vld = 1'b0;
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        grant_idx = IDX_W'(j);
        sel_we    = req_we[j];
        sel_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[j*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: pointer advance, memory issue, tag shift and response capture.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mem_en_d    = grant_vld;
    mem_we_d    = grant_vld & sel_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag0_vld_d  = grant_vld & ~sel_we;
    tag0_idx_d  = grant_idx;
    tag1_vld_d  = tag0_vld_q;
    tag1_idx_d  = tag0_idx_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (grant_vld) begin
      rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
    end
    if (tag1_vld_q) begin
      rsp_valid_d[tag1_idx_q] = 1'b1;
      rsp_rdata_d             = mem_rdata;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag0_vld_q  <= 1'b0;
      tag0_idx_q  <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_idx_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag0_vld_q  <= tag0_vld_d;
      tag0_idx_q  <= tag0_idx_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_idx_q  <= tag1_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Outputs forced low during the first reset cycle too, before the registers clear.
  assign req_ready = grant;
  assign mem_en    = mem_en_q & ~rst;
  assign mem_we    = mem_we_q & ~rst;
  assign mem_addr  = rst ? '0 : mem_addr_q;
  assign mem_wdata = rst ? '0 : mem_wdata_q;
  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_rdata = rst ? '0 : rsp_rdata_q;
  assign busy      = ~rst & (tag0_vld_q | tag1_vld_q | (|rsp_valid_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata = '0;
  logic             busy;

  mem_port_arbiter #(.NUM_REQ(NR), .WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, 1-cycle read latency.
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: rotating priority, in-order memory, fixed 3-cycle read latency.
  typedef struct {
    int unsigned   idx;
    logic [DW-1:0] data;
    int unsigned   due;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] mmem [2**AW];
  int unsigned   cyc = 0;
  int unsigned   mptr = 0;
  bit            p_acc = 0;
  bit            p_we = 0;
  logic [AW-1:0] p_addr = '0, last_addr = '0;
  logic [DW-1:0] p_wdata = '0, last_wdata = '0, last_rdata = '0;

  initial for (int i = 0; i < 2**AW; i++) mmem[i] = '0;

  function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int unsigned p);
    for (int i = int'(p); i < int'(NR); i++) if (v[i]) return NR'(1) << i;
    for (int i = 0; i < int'(p); i++)        if (v[i]) return NR'(1) << i;
    return '0;
  endfunction

  always @(negedge clk) begin
    logic [NR-1:0] exp_g;
    logic          exp_busy;
    rsp_t          e;
    int unsigned   w;
    cyc++;
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      mptr = 0;
      sb.delete();
      p_acc = 0;
      last_addr = '0;
      last_wdata = '0;
      last_rdata = '0;
    end else begin
      exp_g = model_grant(req_valid, mptr);
      chk("grant", req_ready, exp_g);

      if (p_acc) begin
        chk("mem_en", mem_en, 1);
        chk("mem_we", mem_we, p_we);
        chk("mem_addr", mem_addr, p_addr);
        chk("mem_wdata", mem_wdata, p_wdata);
        if (p_we) mmem[p_addr] = p_wdata;
        last_addr  = p_addr;
        last_wdata = p_wdata;
      end else begin
        chk("mem_en_idle", mem_en, 0);
        chk("mem_we_idle", mem_we, 0);
        chk("mem_addr_hold", mem_addr, last_addr);
        chk("mem_wdata_hold", mem_wdata, last_wdata);
      end

      exp_busy = 1'b0;
      foreach (sb[k]) if (sb[k].due <= cyc + 2) exp_busy = 1'b1;
      chk("busy", busy, exp_busy);

      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, NR'(1) << e.idx);
        chk("rsp_rdata", rsp_rdata, e.data);
        last_rdata = e.data;
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
        chk("rsp_rdata_hold", rsp_rdata, last_rdata);
      end

      p_acc = 0;
      if (exp_g != 0) begin
        w = 0;
        for (int i = 0; i < int'(NR); i++) if (exp_g[i]) w = i;
        p_acc   = 1;
        p_we    = req_we[w];
        p_addr  = req_addr[w*AW +: AW];
        p_wdata = req_wdata[w*DW +: DW];
        mptr    = (w + 1) % NR;
        if (!p_we) sb.push_back('{w, mmem[p_addr], cyc + 3});
      end
    end
  end

  // Stimulus
  logic [NR-1:0] hold = '0;

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic cycle();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NR); i++) if (acc[i] && !hold[i]) req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (req_valid != 0 && n < limit) begin
      cycle();
      n++;
    end
    chk("drain_timeout", req_valid, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with every requester asserting valid; first grant afterwards is req 0.
    req_valid = '1;
    repeat (3) cycle();
    rst = 1'b0;
    drain(20);
    repeat (2) cycle();

    // Seed addresses 0..3 with per-requester data.
    for (int i = 0; i < int'(NR); i++) set_req(i, 1'b1, AW'(i), 32'hA000_0000 + DW'(i));
    drain(20);

    // Single write then read by requester 2.
    set_req(2, 1'b1, 8'h10, 32'hDEADBEEF);
    drain(20);
    set_req(2, 1'b0, 8'h10, '0);
    drain(20);
    repeat (4) cycle();

    // Fairness: all four reading continuously from a fresh pointer.
    pulse_rst();
    hold = '1;
    for (int i = 0; i < int'(NR); i++) set_req(i, 1'b0, AW'(i), '0);
    repeat (8) cycle();
    hold = '0;
    drain(20);
    repeat (4) cycle();

    // Pointer skip: after req 1, requesters 0 and 3 compete.
    set_req(1, 1'b0, 8'h05, '0);
    drain(20);
    set_req(0, 1'b0, 8'h01, '0);
    set_req(3, 1'b0, 8'h02, '0);
    drain(20);
    repeat (4) cycle();

    // Write then read of the same address on consecutive cycles.
    pulse_rst();
    set_req(0, 1'b1, 8'h07, 32'h5A5A5A5A);
    set_req(1, 1'b0, 8'h07, '0);
    drain(20);
    repeat (4) cycle();

    // Reset while a read is in flight.
    set_req(3, 1'b0, 8'h10, '0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (6) cycle();

    // Randomised traffic with occasional resets, addresses confined to provoke hazards.
    repeat (3000) begin
      for (int i = 0; i < int'(NR); i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    drain(50);
    repeat (6) cycle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous memory (WIDTH x 2^ADDR_WIDTH, 1-cycle read latency) among NUM_REQ requesters.
- Sits between the requesters and the memory instance, and owns every memory control pin.
- Pipelined: one access is issued per cycle, and each read response is routed back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, data width in bits.
- ADDR_WIDTH, 8, memory address width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_ready  out  NUM_REQ  grant; at most one bit set (one-hot or zero).
- req_we  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WIDTH  packed write data; requester i in slice [i*WIDTH +: WIDTH].
- rsp_valid  out  NUM_REQ  one-hot read-data strobe.
- rsp_rdata  out  WIDTH  read data, shared by all requesters.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid 1 cycle after an mem_en && !mem_we cycle.
- busy  out  1  high while any issued read is still awaiting its response.

Behaviour:
- Reset: one clock, one synchronous active-high reset, rst.
  - While rst is high: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0.
  - rr_ptr resets to 0.
- Grant (combinational, cycle N):
  - Search req_valid starting at index rr_ptr, ascending with wrap-around to index 0.
  - The first set bit i gets req_ready[i] = 1; all other bits are 0.
  - Acceptance is req_valid[i] && req_ready[i].
  - A requester holds valid, we, addr and wdata stable until accepted. req_ready never depends on anything other than req_valid and state.
- Pointer: on acceptance of requester i, rr_ptr <= (i+1) mod NUM_REQ. With no acceptance, rr_ptr holds.
- Issue (cycle N+1):
  - Registered outputs: mem_en = 1, mem_we = req_we[i], mem_addr = req_addr slice i, mem_wdata = req_wdata slice i.
  - If no acceptance in cycle N: mem_en = 0 and mem_we = 0; addr and wdata hold their previous values.
- Read return (cycle N+2):
  - For a read, mem_rdata is valid; rsp_valid[i] = 1 and rsp_rdata = mem_rdata, registered at the end of N+2 and visible in cycle N+3.
  - Total read latency from acceptance to rsp_valid is 3 cycles.
  - Writes produce no response.
- Tag pipeline: a 2-stage shift register carries {valid_read, requester index} alongside the issue so responses are routed correctly.
- Throughput: one acceptance per cycle with no bubbles. Back-to-back reads from different requesters return in issue order, one per cycle.
- Ordering: a write to address A accepted in cycle N, followed by a read of A accepted in cycle N+1, returns the new data (memory is write-first, in sequence).
- busy = OR of the tag-pipeline valid_read bits, plus rsp_valid pending.
- rsp_rdata holds its last value when rsp_valid = 0.
- No response backpressure: the requester must take rsp_rdata in the cycle rsp_valid is high.
- Reset mid-operation: rst clears the tag pipeline. In-flight reads are dropped and no rsp_valid is produced for them after reset deasserts. The first grant after reset starts from index 0.
- Single requester: a lone continuous requester is granted every cycle.
- All requesters valid continuously: grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 cycles after its valid rises.

Test Plan:
- Reset check: assert rst for 3 cycles with all req_valid = 1 -> req_ready = 0, mem_en = 0, rsp_valid = 0, busy = 0 throughout. After release, the first grant goes to req 0.
- Single write/read: req 2 writes addr 0x10 data 0xDEADBEEF, then reads 0x10 -> mem_en/mem_we = 1/1 one cycle after accept. The read gives rsp_valid = 0b0100 with rsp_rdata = 0xDEADBEEF exactly 3 cycles after its accept.
- Fairness: all 4 requesters reading distinct addresses 0..3 continuously for 8 cycles -> req_ready sequence 0001, 0010, 0100, 1000 repeated. rsp_valid follows the same order 3 cycles later, one per cycle, each with that requester's data.
- Pointer skip: after a grant to req 1, only req 0 and req 3 are valid -> req 3 is granted first, then req 0.
- Write-then-read hazard: req 0 writes 0x5A5A5A5A to addr 7; req 1 reads addr 7 in the next cycle -> req 1 receives 0x5A5A5A5A.
- Reset mid-read: accept a read from req 3, assert rst one cycle later for 1 cycle -> no rsp_valid ever appears for that read, and busy = 0 after reset.
